// File: rtl/way_line_serializer.sv
// -----------------------------------------------------------------------------
// way_line_serializer
//
// Registered way-select for the set-associative cache datapath. On an accepted
// request it captures the hit way's line from WAYS parallel way-data buses,
// selected by a one-hot hit vector. It then streams that line out as BEATS
// narrow beats over a valid/ready handshake. When CWF is set, the stream starts
// at the beat holding the requested byte (critical word first) and wraps.
// A zero-hot select (miss) or multi-hot select (tag-compare error) produces a
// one-cycle flag and no beats, so the block never silently picks a way.
//
// Ports:
//   i_clk         clock
//   i_rst         asynchronous, active-high reset
//   i_data[WAYS]  line data for each way
//   i_sel         one-hot way hit vector
//   i_offset      requested byte offset within the line
//   i_valid       request valid
//   o_ready       block can accept a request (IDLE)
//   o_beat        beat data
//   o_beat_valid  beat valid (SEND)
//   i_beat_ready  downstream accepts the beat
//   o_beat_idx    line-relative index of the current beat
//   o_last        current beat is the final beat of the line
//   o_miss        one-cycle pulse: accepted request had i_sel == 0
//   o_err_multi   one-cycle pulse: accepted request had >1 i_sel bits set
// -----------------------------------------------------------------------------
module way_line_serializer #(
    parameter  int LINE_SIZE_BYTES = 64,
    parameter  int WAYS            = 4,
    parameter  int BUS_BYTES       = 8,
    parameter  int CWF             = 1,
    localparam int LINE_W          = LINE_SIZE_BYTES * 8,
    localparam int BUS_W           = BUS_BYTES * 8,
    localparam int BEATS           = LINE_SIZE_BYTES / BUS_BYTES,
    localparam int OFF_W           = $clog2(LINE_SIZE_BYTES),
    localparam int IDX_W           = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LINE_W-1:0] i_data [WAYS],
    input  logic [WAYS-1:0]   i_sel,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [BUS_W-1:0]  o_beat,
    output logic              o_beat_valid,
    input  logic              i_beat_ready,
    output logic [IDX_W-1:0]  o_beat_idx,
    output logic              o_last,
    output logic              o_miss,
    output logic              o_err_multi
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [LINE_W-1:0]  r_line;
    logic [IDX_W-1:0]   r_beat_idx;
    logic [IDX_W-1:0]   r_sent;
    logic               r_miss;
    logic               r_err_multi;

    logic [LINE_W-1:0]  w_sel_line;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_idx_inc;
    logic               w_sel_zero;
    logic               w_sel_multi;
    logic               w_accept;
    logic               w_load;
    logic               w_beat_fire;

    // Clearing the lowest set bit leaves a non-zero value only when two or
    // more bits are set.
    assign w_sel_zero  = (i_sel == '0);
    assign w_sel_multi = ((i_sel & (i_sel - WAYS'(1))) != '0);

    // AND-OR way mux. Exact for a one-hot select; a multi-hot result is never
    // loaded, so the merged value is harmless.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_sel_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (i_sel[w]) begin
                w_sel_line = w_sel_line | i_data[w];
            end
        end
    end

    // Start beat is the beat holding the requested byte; offset bits below
    // the bus width fall away in the shift. A single-beat line always
    // starts at 0.
    assign w_start = (CWF != 0 && BEATS > 1)
                   ? IDX_W'(i_offset >> $clog2(BUS_BYTES))
                   : '0;

    // The index is exactly log2(BEATS) wide, so natural overflow wraps
    // BEATS-1 back to 0.
    assign w_idx_inc = (BEATS > 1) ? (r_beat_idx + IDX_W'(1)) : '0;

    assign w_accept    = i_valid && o_ready;
    assign w_load      = w_accept && !w_sel_zero && !w_sel_multi;
    assign w_beat_fire = o_beat_valid && i_beat_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: asynchronous reset appears in the sensitivity list, so outputs
    // decoded from state drop the moment i_rst rises, without waiting for a clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_beat_valid = 1'b0;
        o_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (w_load) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                o_beat_valid = 1'b1;
                o_last       = (r_sent == IDX_W'(BEATS - 1));
                if (i_beat_ready && o_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: line capture, beat index, sent count, outcome pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the line register is reset as well, so an aborted line
            // leaves no residue visible on the beat bus.
            r_line      <= '0;
            r_beat_idx  <= '0;
            r_sent      <= '0;
            r_miss      <= 1'b0;
            r_err_multi <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_miss      <= w_accept && w_sel_zero;
            r_err_multi <= w_accept && w_sel_multi;
            if (w_load) begin
                r_line     <= w_sel_line;
                r_beat_idx <= w_start;
                r_sent     <= '0;
            end else if (w_beat_fire) begin
                r_beat_idx <= w_idx_inc;
                r_sent     <= r_sent + IDX_W'(1);
            end
        end
    end

    // The beat bus is forced to zero outside SEND so a stale line never
    // appears on it while idle.
    assign o_beat      = (r_state == S_SEND) ? r_line[r_beat_idx * BUS_W +: BUS_W] : '0;
    assign o_beat_idx  = r_beat_idx;
    assign o_miss      = r_miss;
    assign o_err_multi = r_err_multi;

endmodule

// File: doc/way_line_serializer.md
Name: way_line_serializer

Overview:
- Registered successor to the combinational way-select mux in the set-associative cache datapath.
- Captures the hit way's line from WAYS parallel way-data buses, using a one-hot way select.
- Streams the captured line to the refill/response bus as BEATS narrow beats over a valid/ready handshake, optionally critical-word-first.
- Flags zero-hot selects (miss) and multi-hot selects (tag-compare error) instead of silently picking a way.

Parameters:
- LINE_SIZE_BYTES, 64, cache line size in bytes.
- WAYS, 4, associativity (number of way-data inputs); must be at least 2.
- BUS_BYTES, 8, output beat width in bytes. LINE_SIZE_BYTES must be a multiple of BUS_BYTES, and BEATS = LINE_SIZE_BYTES/BUS_BYTES must be a power of two.
- CWF, 1, 1 = critical-word-first start beat; 0 = always start at beat 0.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_data  input  [LINE_SIZE_BYTES*8-1:0] x WAYS (unpacked array)  line data for each way.
- i_sel  input  WAYS  one-hot way hit vector.
- i_offset  input  clog2(LINE_SIZE_BYTES)  requested byte offset within the line.
- i_valid  input  1  request valid.
- o_ready  output  1  block can accept a request.
- o_beat  output  BUS_BYTES*8  beat data.
- o_beat_valid  output  1  beat valid.
- i_beat_ready  input  1  downstream accepts the beat.
- o_beat_idx  output  clog2(BEATS) (min 1)  line-relative index of the current beat.
- o_last  output  1  current beat is the final beat of the line.
- o_miss  output  1  one-cycle pulse: accepted request had i_sel == 0.
- o_err_multi  output  1  one-cycle pulse: accepted request had more than one i_sel bit set.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-high on i_rst.
- Reset values: state = IDLE, o_ready = 1, o_beat_valid = 0, o_last = 0, o_miss = 0, o_err_multi = 0, o_beat = 0, o_beat_idx = 0, line register = 0, beat counter = 0.
- States:
  - IDLE: o_ready = 1, o_beat_valid = 0.
  - SEND: o_ready = 0, o_beat_valid = 1.
- Accept: a request is accepted on i_valid && o_ready at a rising edge. Acceptance only occurs in IDLE. Each accepted request produces exactly one outcome:
  - popcount(i_sel) == 0: o_miss = 1 for the next cycle only. Stay in IDLE. No beats are produced and the line register is unchanged.
  - popcount(i_sel) >= 2: o_err_multi = 1 for the next cycle only. Stay in IDLE. No beats are produced.
  - popcount(i_sel) == 1: register i_data[w], where w is the set bit. Set start = CWF ? i_offset / BUS_BYTES : 0. Set beat_idx = start and sent = 0. Enter SEND.
- Latency: the first beat is valid on the cycle after acceptance. The block samples i_data only on the accept edge and may change freely afterwards.
- SEND:
  - o_beat = line[beat_idx*BUS_BYTES*8 +: BUS_BYTES*8].
  - o_last = (sent == BEATS-1).
  - On i_beat_ready: beat_idx = (beat_idx + 1) mod BEATS, wrapping from BEATS-1 to 0, and sent increments.
  - The handshake on the beat with o_last = 1 returns the block to IDLE. o_beat_valid and o_last drop on the following cycle.
- Backpressure: while o_beat_valid && !i_beat_ready, o_beat, o_beat_idx and o_last hold stable and beat_idx does not advance.
- Throughput: there is one IDLE cycle between lines; o_ready rises the cycle after the last-beat handshake. Maximum rate is BEATS+1 cycles per line.
- BEATS == 1: the single beat has o_last = 1. beat_idx is always 0 and i_offset is ignored.
- Offset bits below clog2(BUS_BYTES) are ignored.
- Reset mid-SEND: the remaining beats are discarded and all outputs take their reset values immediately (asynchronous). The first cycle after deassertion is IDLE with o_ready = 1.
- i_valid while in SEND is ignored. Upstream must hold the request until o_ready.

Test Plan:
- Defaults, CWF = 1: i_sel = 4'b0100, i_data[2] bytes = 0x00..0x3F, i_offset = 0x18, i_beat_ready held 1 -> beats with o_beat_idx 3,4,5,6,7,0,1,2. First beat o_beat = 0x1F1E1D1C1B1A1918. o_last only on idx 2. o_ready returns 9 cycles after accept.
- i_sel = 4'b0000 with i_valid -> o_miss pulses exactly 1 cycle, no o_beat_valid, o_ready stays 1. Then i_sel = 4'b1010 -> o_err_multi pulses 1 cycle, no beats.
- Backpressure, CWF = 0: i_sel = 4'b0001, i_beat_ready toggles 1,0,0,1,... -> o_beat and o_beat_idx are held across the stalled cycles. Exactly 8 beats arrive in order 0..7 with no duplication or loss.
- i_rst asserted after the 3rd beat handshake -> o_beat_valid = 0 in the same cycle. After deassertion, a new request on way 1 yields a complete 8-beat line with beat 0 first (CWF = 0) and no residue from the old line.
- Parameter sweep: WAYS = 8, BUS_BYTES = 64 (BEATS = 1), i_sel = 8'h80 -> single beat equal to i_data[7] with o_last = 1. Back-to-back requests are accepted every 2 cycles.
